mult_div_engine: RTL and testbench

- Multi-cycle multiply/divide responder that owns the architectural HI/LO registers.
- The execute stage is the initiator: it presents operands, a one-cycle start strobe and an opcode, then stalls dependent instructions while busy is high.
- Also services direct HI/LO writes (mthi/mtlo) and a cancel input, so a start from an instruction killed by an exception never commits.

---
 rtl/mult_div_engine.sv | 140 ++++++++++++++
 tb/tb_mult_div_engine.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mult_div_engine.sv
// rtl/mult_div_engine.sv - multi-cycle multiply/divide engine owning the HI/LO registers
// The result is computed when the op is accepted and committed after a fixed busy phase.
module mult_div_engine #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic [2:0]  MULT_DIV_OP,
  input  logic        MTHI,
  input  logic        MTLO,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_n;
  logic [CW-1:0] count, count_n;
  logic [31:0]   pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic          pend_we, pend_we_n;
  logic [31:0]   hi_q, hi_n, lo_q, lo_n;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] sq_mag, sr_mag, sq, sr, uq, ur;
  logic        accept;

  // Signed divide works on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
  always_comb begin
    prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u     = {32'd0, A} * {32'd0, B};
    a_mag      = A[31] ? -A : A;
    b_mag      = B[31] ? -B : B;
    b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    b_safe     = (B == 32'd0) ? 32'd1 : B;
    sq_mag     = a_mag / b_mag_safe;
    sr_mag     = a_mag % b_mag_safe;
    sq         = (A[31] ^ B[31]) ? -sq_mag : sq_mag;
    sr         = A[31] ? -sr_mag : sr_mag;
    uq         = A / b_safe;
    ur         = A % b_safe;
  end

  assign accept = (state == IDLE) && start && !MULT_DIV_OP[2] && !cancel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_n;
      count   <= count_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_we <= pend_we_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_we_n = pend_we;
    hi_n      = hi_q;
    lo_n      = lo_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = RUN;
          case (MULT_DIV_OP[1:0])
            2'd0: begin
              {pend_hi_n, pend_lo_n} = prod_s;
              pend_we_n = 1'b1;
              count_n   = CW'(MULT_CYCLES - 1);
            end
            2'd1: begin
              {pend_hi_n, pend_lo_n} = prod_u;
              pend_we_n = 1'b1;
              count_n   = CW'(MULT_CYCLES - 1);
            end
            2'd2: begin
              pend_hi_n = sr;
              pend_lo_n = sq;
              pend_we_n = (B != 32'd0);
              count_n   = CW'(DIV_CYCLES - 1);
            end
            default: begin
              pend_hi_n = ur;
              pend_lo_n = uq;
              pend_we_n = (B != 32'd0);
              count_n   = CW'(DIV_CYCLES - 1);
            end
          endcase
        end else if (!cancel) begin
          if (MTHI) hi_n = A;
          if (MTLO) lo_n = A;
        end
      end
      RUN: begin
        // cancel beats completion, including on the final edge
        if (cancel || count == '0) begin
          if (!cancel && pend_we) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
          state_n   = IDLE;
          count_n   = '0;
          pend_hi_n = '0;
          pend_lo_n = '0;
          pend_we_n = 1'b0;
        end else begin
          count_n = count - CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_engine.sv
// tb/tb_mult_div_engine.sv - directed self-checking bench for mult_div_engine
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_mult_div_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic        start;
  logic [2:0]  op;
  logic        mthi, mtlo, cancel;
  logic        busy;
  logic [31:0] hi, lo;

  int n_pass = 0;
  int n_total = 0;

  mult_div_engine #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .start(start), .MULT_DIV_OP(op),
    .MTHI(mthi), .MTLO(mtlo), .cancel(cancel), .busy(busy), .HI(hi), .LO(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an op: start is sampled on the next edge, then dropped.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  // Count busy cycles; also record whether HI/LO moved while busy.
  task automatic run_busy(output int n, output logic moved);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo; n = 0; moved = 1'b0;
    while (busy && n < 100) begin
      if (hi !== h0 || lo !== l0) moved = 1'b1;
      n++;
      tick();
    end
  endtask

  task automatic mt(input logic h, input logic l, input logic [31:0] v);
    mthi = h; mtlo = l; a = v;
    tick();
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  int   n;
  logic moved;
  logic rose;

  initial begin
    reset = 1'b1; a = '0; b = '0; start = 1'b0; op = '0;
    mthi = 1'b0; mtlo = 1'b0; cancel = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    check("mult_busy_after_start", 32'(busy), 32'd1);
    run_busy(n, moved);
    check("mult_cycles", n, 32'd5);
    check("mult_hilo_stable", 32'(moved), 32'd0);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_busy(n, moved);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    run_busy(n, moved);
    check("div_cycles", n, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    issue(3'd3, 32'd7, 32'd2);
    run_busy(n, moved);
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_busy(n, moved);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'd0);

    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    check("mthi", hi, 32'h11);
    check("mtlo", lo, 32'h22);

    issue(3'd2, 32'd100, 32'd0);
    run_busy(n, moved);
    check("div0_cycles", n, 32'd10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    // Cancel in the third busy cycle.
    issue(3'd0, 32'd5, 32'd6);
    tick(); tick();
    check("cancel_still_busy", 32'(busy), 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy_drop", 32'(busy), 32'd0);
    repeat (8) tick();
    check("cancel_hi", hi, 32'h11);
    check("cancel_lo", lo, 32'h22);

    // Cancel on the completion edge (5th busy cycle).
    issue(3'd0, 32'd5, 32'd6);
    repeat (4) tick();
    check("late_cancel_busy", 32'(busy), 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("late_cancel_idle", 32'(busy), 32'd0);
    check("late_cancel_lo", lo, 32'h22);

    // start+cancel together, also carrying an MTHI that must be dropped.
    cancel = 1'b1; mthi = 1'b1;
    issue(3'd0, 32'h77, 32'd2);
    cancel = 1'b0; mthi = 1'b0;
    rose = 1'b0;
    repeat (6) begin
      if (busy) rose = 1'b1;
      tick();
    end
    check("start_cancel_busy", 32'(rose), 32'd0);
    check("start_cancel_mthi", hi, 32'h11);

    issue(3'd5, 32'd3, 32'd4);
    check("reserved_op_busy", 32'(busy), 32'd0);

    // MTHI while busy is ignored.
    issue(3'd3, 32'd9, 32'd4);
    mt(1'b1, 1'b1, 32'hDEAD);
    check("mthi_busy_hi", hi, 32'h11);
    check("mtlo_busy_lo", lo, 32'h22);
    run_busy(n, moved);
    check("divu2_lo", lo, 32'd2);
    check("divu2_hi", hi, 32'd1);

    // Async reset mid-divide, checked before the next edge.
    issue(3'd2, 32'd50, 32'd7);
    tick(); tick();
    reset = 1'b1;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_hi", hi, 32'd0);
    check("async_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    repeat (12) tick();
    check("post_reset_lo", lo, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
